alu4_seq_ctrl: RTL and testbench

- Nibble-serial sequencer that executes WIDTH-bit add, subtract, pass and decrement on the team's existing 4-bit combinational ALU.
- Drives the ALU's P/A/B inputs one nibble per cycle, LSB first.
- Chains each nibble's C4 into the next nibble's carry-in (P[0]).
- Assembles the wide result and reports flags through a start/busy/done handshake.
- Sits between the register file/control FSM and one shared ALU4 instance.

---
 rtl/alu4_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_alu4_seq_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu4_seq_ctrl.sv
// Nibble-serial sequencer: runs WIDTH-bit ADD/SUB/PASS/DEC on one shared 4-bit ALU,
// LSB nibble first, chaining carry through ALU_P[0], with a start/busy/done handshake.
module alu4_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             vf,
    output logic             cf,
    output logic [3:0]       alu_p,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_r,
    input  logic             alu_v,
    input  logic             alu_c4
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IW-1:0]    idx_r;
    logic [1:0]       op_lat_r;
    logic [WIDTH-1:0] a_lat_r;
    logic [WIDTH-1:0] b_lat_r;
    logic [WIDTH-1:0] work_r;

    logic [IW-1:0]    idx_next_s;
    logic             last_s;
    logic [WIDTH-1:0] work_next_s;

    function automatic logic [3:0] nib_sel(input logic [WIDTH-1:0] v, input logic [IW-1:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

    // Next step index and the working result with the current ALU nibble merged in.
    always_comb begin
        idx_next_s  = idx_r + 1'b1;
        last_s      = (idx_r == IW'(NIB - 1));
        work_next_s = work_r;
        work_next_s[{idx_r, 2'b00} +: 4] = alu_r;
    end

    // Sequencer FSM; alu_p[0] doubles as the registered carry between nibbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= {IW{1'b0}};
            op_lat_r <= 2'b00;
            a_lat_r  <= {WIDTH{1'b0}};
            b_lat_r  <= {WIDTH{1'b0}};
            work_r   <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= {WIDTH{1'b0}};
            zf       <= 1'b0;
            vf       <= 1'b0;
            cf       <= 1'b0;
            alu_p    <= 4'd0;
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_lat_r  <= a;
                        b_lat_r  <= b;
                        op_lat_r <= op;
                        idx_r    <= {IW{1'b0}};
                        busy     <= 1'b1;
                        alu_a    <= a[3:0];
                        alu_b    <= b[3:0];
                        alu_p    <= {1'b0, op, (op == OP_SUB)};
                        state_r  <= ST_RUN;
                    end else begin
                        busy  <= 1'b0;
                        alu_p <= 4'd0;
                        alu_a <= 4'd0;
                        alu_b <= 4'd0;
                    end
                end
                ST_RUN: begin
                    work_r <= work_next_s;
                    idx_r  <= idx_next_s;
                    if (last_s) begin
                        result  <= work_next_s;
                        zf      <= (work_next_s == {WIDTH{1'b0}});
                        vf      <= alu_v;
                        cf      <= alu_c4;
                        done    <= 1'b1;
                        alu_p   <= 4'd0;
                        alu_a   <= 4'd0;
                        alu_b   <= 4'd0;
                        state_r <= ST_DONE;
                    end else begin
                        alu_p <= {1'b0, op_lat_r, alu_c4};
                        alu_a <= nib_sel(a_lat_r, idx_next_s);
                        alu_b <= nib_sel(b_lat_r, idx_next_s);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    alu_p   <= 4'd0;
                    alu_a   <= 4'd0;
                    alu_b   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Directed bench for alu4_seq_ctrl (WIDTH=16) with a behavioural 4-bit ALU model
// answering the sequencer's nibble requests.
module tb_alu4_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, zf, vf, cf;
    logic [15:0] result;
    logic [3:0]  alu_p, alu_a, alu_b, alu_r;
    logic        alu_v, alu_c4;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int lat;
    int dc0;
    logic [3:0] p_log [4];
    logic [3:0] a_log [4];
    logic [33:0] snap;

    alu4_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zf(zf), .vf(vf), .cf(cf),
        .alu_p(alu_p), .alu_a(alu_a), .alu_b(alu_b),
        .alu_r(alu_r), .alu_v(alu_v), .alu_c4(alu_c4)
    );

    always #5 clk = ~clk;

    // Reference 4-bit ALU: P[2:1] selects A+B, A+~B, A, A+1111; P[0] is carry-in.
    logic [3:0] m_b;
    logic [4:0] m_s;
    always_comb begin
        m_b = 4'h0;
        case (alu_p[2:1])
            2'b00:   m_b = alu_b;
            2'b01:   m_b = ~alu_b;
            2'b11:   m_b = 4'hF;
            default: m_b = 4'h0;
        endcase
        m_s = {1'b0, alu_a} + {1'b0, m_b} + {4'h0, alu_p[0]};
        if (alu_p[2:1] == 2'b10) begin
            alu_r  = alu_a;
            alu_c4 = 1'b0;
            alu_v  = 1'b0;
        end else begin
            alu_r  = m_s[3:0];
            alu_c4 = m_s[4];
            alu_v  = (alu_a[3] == m_b[3]) && (m_s[3] != alu_a[3]);
        end
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation at a negedge, scramble inputs afterwards, wait for DONE (bounded).
    task automatic run_op(input logic [1:0] o, input logic [15:0] ia, input logic [15:0] ib,
                          input bit repulse);
        op = o; a = ia; b = ib; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            a = ~ia; b = ib ^ 16'h5A5A; op = ~o;
            if (k <= 4) begin
                p_log[k-1] = alu_p;
                a_log[k-1] = alu_a;
            end
            if (repulse && k == 2) start = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {busy, done, result, zf, vf, cf, alu_p, alu_a, alu_b},
            {2'b00, 16'h0, 3'b000, 4'h0, 4'h0, 4'h0});
        rst_n = 1'b1;
        @(negedge clk);

        // ADD overflow into the sign bit
        run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        chk("add_latency", lat, 5);
        chk("add_result", result, 16'h8000);
        chk("add_flags", {zf, vf, cf}, 3'b010);
        chk("add_cin_seq", {p_log[0][0], p_log[1][0], p_log[2][0], p_log[3][0]}, 4'b0111);
        chk("add_a_nibbles", {a_log[3], a_log[2], a_log[1], a_log[0]}, 16'h7FFF);

        // SUB equal operands
        run_op(2'b01, 16'h1234, 16'h1234, 1'b0);
        chk("sub0_result", result, 16'h0000);
        chk("sub0_flags", {zf, vf, cf}, 3'b101);
        chk("sub0_p_seq", {p_log[3], p_log[2], p_log[1], p_log[0]}, 16'h3333);

        // SUB with borrow, then DEC across the sign boundary
        run_op(2'b01, 16'h0000, 16'h0001, 1'b0);
        chk("sub_borrow_result", result, 16'hFFFF);
        chk("sub_borrow_flags", {zf, vf, cf}, 3'b000);
        run_op(2'b11, 16'h8000, 16'h1234, 1'b0);
        chk("dec_result", result, 16'h7FFF);
        chk("dec_flags", {zf, vf, cf}, 3'b011);
        chk("dec_p_seq", {p_log[3], p_log[2], p_log[1], p_log[0]}, 16'h6666);

        // START re-pulsed during RUN is ignored; back-to-back START after DONE accepted
        dc0 = done_cnt;
        run_op(2'b00, 16'h1111, 16'h2222, 1'b1);
        chk("repulse_latency", lat, 5);
        chk("repulse_result", result, 16'h3333);
        chk("idle_after_done_busy", busy, 1'b0);
        run_op(2'b00, 16'h0001, 16'h0002, 1'b0);
        chk("b2b_latency", lat, 5);
        chk("b2b_result", result, 16'h0003);
        chk("repulse_done_count", done_cnt - dc0, 2);

        // Reset during RUN step 2
        dc0 = done_cnt;
        op = 2'b00; a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrun_reset_outs", {busy, done, result, zf, vf, cf, alu_p, alu_a, alu_b},
               {2'b00, 16'h0, 3'b000, 4'h0, 4'h0, 4'h0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrun_reset_no_done", done_cnt - dc0, 0);
        run_op(2'b10, 16'hABCD, 16'hFFFF, 1'b0);
        chk("pass_latency", lat, 5);
        chk("pass_result", result, 16'hABCD);
        chk("pass_flags", {zf, vf, cf}, 3'b000);

        // Operands change after acceptance, then results held through idle
        run_op(2'b00, 16'h00FF, 16'h0001, 1'b0);
        chk("iso_result", result, 16'h0100);
        chk("iso_flags", {zf, vf, cf}, 3'b000);
        snap = {2'b00, result, zf, vf, cf, 13'h0};
        for (int i = 0; i < 10; i++) begin
            a = 16'h0F0F ^ 16'(i); b = 16'hF0F0; op = 2'(i);
            @(negedge clk);
            chk("idle_hold", {busy, done, result, zf, vf, cf, 13'h0}, snap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
